registerfile_mp: RTL

// - Parametrised multi-port register file; next generation of the MIPS datapath register file.
// - Configurable width, depth, read-port count and write-port count, optional hardwired-zero R0.
// - Reset clears the array one row per cycle (RAM-friendly), so the block reports busy until clear completes.
// - Sits between decode (read addresses) and writeback (write ports) in single- and dual-issue pipelines.

---
 rtl/registerfile_mp_pkg.sv | 19 +
 rtl/regfile_clear_seq.sv | 50 +++++
 rtl/registerfile_mp.sv | 104 ++++++++++
 3 files changed

// File: rtl/registerfile_mp_pkg.sv
// Shared types and defaults for the multi-port register file: clear-sequencer
// state encodings, default geometry, and the address-qualification helper.
package registerfile_mp_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } regfile_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = 5;

    // An address is usable if it is inside the array and is not the hardwired zero row.
    function automatic logic addr_ok(input int addr, input int depth, input bit zero_reg);
        return (addr < depth) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Reset clear sequencer: after reset, walks every row once writing zero, and
// holds busy high until the last row has been cleared.
module regfile_clear_seq
    import registerfile_mp_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    regfile_state_t    state_reg, state_next;
    logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        clr_we       = 1'b0;
        if (state_reg == ST_CLEAR) begin
            // The reset cycle itself does not count as a clear step.
            clr_we = ~rst;
            if (clr_ptr_reg == LAST_ROW) begin
                state_next   = ST_RUN;
                clr_ptr_next = '0;
            end else begin
                clr_ptr_next = clr_ptr_reg + 1'b1;
            end
        end
    end

    assign busy     = (state_reg == ST_CLEAR);
    assign clr_addr = clr_ptr_reg;

endmodule

// File: rtl/registerfile_mp.sv
// Parametrised multi-port register file with row-by-row reset clear.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read registers.
module registerfile_mp
    import registerfile_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*ADDR_W-1:0] waddr,
    input  logic [NWR*DATA_W-1:0] wdata,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic                  busy
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic [ADDR_W-1:0] waddr_arr [NWR];
    logic [DATA_W-1:0] wdata_arr [NWR];
    logic [NWR-1:0]    wq;

    regfile_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NWR; gi++) begin : g_wport
            assign waddr_arr[gi] = waddr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
            assign wq[gi] = we[gi] & ~rst & ~busy
                          & addr_ok(int'(waddr_arr[gi]), DEPTH, ZERO_EN);
        end
    endgenerate

    // Later ports are applied last, so the highest-index port wins a conflict.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end
        for (int k = 0; k < NWR; k++) begin
            if (wq[k]) begin
                mem[waddr_arr[k]] <= wdata_arr[k];
            end
        end
    end

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rport
            logic [ADDR_W-1:0] ra;
            logic              rd_ok;
            logic [DATA_W-1:0] rd_val;
            logic [DATA_W-1:0] rdata_reg;

            assign ra    = raddr[gi*ADDR_W +: ADDR_W];
            assign rd_ok = addr_ok(int'(ra), DEPTH, ZERO_EN);

`ifdef REGFILE_BYPASS_EN
            always_comb begin
                rd_val = mem[ra];
                for (int k = 0; k < NWR; k++) begin
                    if (wq[k] && (waddr_arr[k] == ra)) begin
                        rd_val = wdata_arr[k];
                    end
                end
            end
`else
            assign rd_val = mem[ra];
`endif

            always_ff @(posedge clk) begin
                if (rst || busy) begin
                    rdata_reg <= '0;
                end else if (rd_ok) begin
                    rdata_reg <= rd_val;
                end else begin
                    rdata_reg <= '0;
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] = rdata_reg;
        end
    endgenerate

endmodule
